// File: rtl/fetch_ctrl.sv
// Fetch controller: picks the next PC (sequential, redirect, boot, halt) and drives IF/ID valid/flush.
// Zero-latency combinational outputs; a redirect flushes for one bubble cycle and stalls hold the PC.
module fetch_ctrl #(
    parameter int INST_MEMORY_SIZE = 1024,
    parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
    parameter int BOOT_CYCLES      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_curr,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_addr,
    input  logic        halt_req,
    output logic [63:0] pc_next,
    output logic        pc_stall,
    output logic        if_id_flush,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic [1:0]  state,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              boot_cnt_q, boot_cnt_d;
    logic                    misalign_q, misalign_d;
    logic [15:0]             count_q, count_d;
    logic [ADDR_WIDTH-1:0]   seq_addr;
    logic [63:0]             seq_pc;
    logic [63:0]             tgt_pc;
    logic                    tgt_misaligned;
    logic                    unused_hi;

    // Addresses live in a power-of-two window, so the upper PC bits are dropped.
    assign seq_addr       = pc_curr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(4);
    assign seq_pc         = {{(64-ADDR_WIDTH){1'b0}}, seq_addr};
    assign tgt_pc         = {{(64-ADDR_WIDTH){1'b0}}, redirect_addr[ADDR_WIDTH-1:0]};
    assign tgt_misaligned = (redirect_addr[1:0] != 2'b00);
    assign unused_hi      = ^{pc_curr[63:ADDR_WIDTH], redirect_addr[63:ADDR_WIDTH]};

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        misalign_d  = misalign_q;
        count_d     = count_q;
        pc_next     = seq_pc;
        pc_stall    = 1'b1;
        if_id_flush = 1'b0;
        if_id_valid = 1'b0;

        case (state_q)
            BOOT: begin
                pc_next    = 64'd0;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN, FLUSH: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (redirect_valid && tgt_misaligned) begin
                    misalign_d  = 1'b1;
                    if_id_flush = 1'b1;
                    state_d     = HALT;
                end else if (redirect_valid) begin
                    // Redirect wins over a hazard stall: the PC must load the target now.
                    pc_next     = tgt_pc;
                    pc_stall    = 1'b0;
                    if_id_flush = 1'b1;
                    state_d     = FLUSH;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end else if (hazard_stall) begin
                    state_d = state_q;
                end else begin
                    pc_stall    = 1'b0;
                    if_id_valid = (state_q == RUN);
                    state_d     = RUN;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            boot_cnt_q <= 4'd0;
            misalign_q <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign state          = state_q;
    assign misalign_err   = misalign_q;
    assign redirect_count = count_q;

endmodule
